// File: rtl/mm_job_scheduler.sv
// mm_job_scheduler: descriptor FIFO feeding a single-job launcher for noc_mm_top, one completion per job.
// Optional watchdog: define MM_JOB_TIMEOUT_EN for the BUSY timeout (status 10) and sticky hung state.
module mm_job_scheduler #(
  parameter int          MATRIXSIZE_W = 24,
  parameter int          ADDR_W       = 64,
  parameter int          TAG_W        = 8,
  parameter int          JOB_DEPTH    = 4,
  parameter int unsigned TIMEOUT_CYC  = 1048576
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [MATRIXSIZE_W-1:0] job_M1,
  input  logic [MATRIXSIZE_W-1:0] job_M2,
  input  logic [MATRIXSIZE_W-1:0] job_M3,
  input  logic [ADDR_W-1:0]       job_addr_a,
  input  logic [ADDR_W-1:0]       job_addr_b,
  input  logic [ADDR_W-1:0]       job_addr_d,
  input  logic [TAG_W-1:0]        job_tag,
  output logic                    mm_start,
  output logic [MATRIXSIZE_W-1:0] mm_M1,
  output logic [MATRIXSIZE_W-1:0] mm_M2,
  output logic [MATRIXSIZE_W-1:0] mm_M3,
  output logic [ADDR_W-1:0]       mm_addr_matrix_a,
  output logic [ADDR_W-1:0]       mm_addr_matrix_b,
  output logic [ADDR_W-1:0]       mm_addr_matrix_d,
  input  logic                    mm_done,
  input  logic                    mm_error,
  output logic                    cpl_valid,
  input  logic                    cpl_ready,
  output logic [TAG_W-1:0]        cpl_tag,
  output logic [1:0]              cpl_status,
  output logic                    busy,
  output logic [15:0]             jobs_ok,
  output logic [15:0]             jobs_err
);

  localparam int PTR_W = $clog2(JOB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (JOB_DEPTH < 2 || (JOB_DEPTH & (JOB_DEPTH - 1)) != 0 || TIMEOUT_CYC == 0) begin : g_param_check
    $error("mm_job_scheduler: JOB_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC nonzero");
  end

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY, S_REPORT} state_e;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_ERR = 2'b01, ST_TIMEOUT = 2'b10} status_e;

  typedef struct packed {
    logic [MATRIXSIZE_W-1:0] m1;
    logic [MATRIXSIZE_W-1:0] m2;
    logic [MATRIXSIZE_W-1:0] m3;
    logic [ADDR_W-1:0]       addr_a;
    logic [ADDR_W-1:0]       addr_b;
    logic [ADDR_W-1:0]       addr_d;
    logic [TAG_W-1:0]        tag;
  } job_t;

  job_t             fifo_mem [JOB_DEPTH];
  job_t             job_in;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, hung;

  state_e           state_q;
  job_t             mm_job_q;
  logic             mm_start_q;
  logic             cpl_valid_q;
  logic [TAG_W-1:0] cpl_tag_q;
  status_e          cpl_status_q;
  logic [15:0]      jobs_ok_q, jobs_err_q;

`ifdef MM_JOB_TIMEOUT_EN
  logic [31:0]      timer_q;
  logic             hung_q;
  assign hung = hung_q;
`else
  assign hung = 1'b0;
`endif

  assign job_in    = '{m1: job_M1, m2: job_M2, m3: job_M3, addr_a: job_addr_a,
                       addr_b: job_addr_b, addr_d: job_addr_d, tag: job_tag};
  assign job_ready = (count_q != CNT_W'(JOB_DEPTH));
  assign push      = job_valid & job_ready;
  // Pop only from IDLE on registered count, so a fresh push never falls through in the same cycle.
  assign pop       = (state_q == S_IDLE) && (count_q != '0) && !hung;

  // NOTE: always_comb assigns a default before any condition, so no latch can be inferred.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // NOTE: descriptor storage has no reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= job_in;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mm_job_q     <= '0;
      mm_start_q   <= 1'b0;
      cpl_valid_q  <= 1'b0;
      cpl_tag_q    <= '0;
      cpl_status_q <= ST_OK;
      jobs_ok_q    <= '0;
      jobs_err_q   <= '0;
`ifdef MM_JOB_TIMEOUT_EN
      timer_q      <= '0;
      hung_q       <= 1'b0;
`endif
    end else begin
      mm_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            mm_job_q   <= fifo_mem[rd_ptr_q];
            mm_start_q <= 1'b1;
            state_q    <= S_LAUNCH;
`ifdef MM_JOB_TIMEOUT_EN
            timer_q    <= '0;
`endif
          end
        end
        S_LAUNCH: state_q <= S_BUSY;
        S_BUSY: begin
`ifdef MM_JOB_TIMEOUT_EN
          timer_q <= timer_q + 32'd1;
`endif
          // An engine error wins over a simultaneous done; either wins over the watchdog.
          if (mm_error || mm_done) begin
            cpl_valid_q  <= 1'b1;
            cpl_tag_q    <= mm_job_q.tag;
            cpl_status_q <= mm_error ? ST_ERR : ST_OK;
            state_q      <= S_REPORT;
          end
`ifdef MM_JOB_TIMEOUT_EN
          else if (timer_q == 32'(TIMEOUT_CYC - 1)) begin
            cpl_valid_q  <= 1'b1;
            cpl_tag_q    <= mm_job_q.tag;
            cpl_status_q <= ST_TIMEOUT;
            hung_q       <= 1'b1;
            state_q      <= S_REPORT;
          end
`endif
        end
        S_REPORT: begin
          if (cpl_ready) begin
            cpl_valid_q <= 1'b0;
            if (cpl_status_q == ST_OK) jobs_ok_q  <= jobs_ok_q + 16'd1;
            else                       jobs_err_q <= jobs_err_q + 16'd1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mm_start         = mm_start_q;
  assign mm_M1            = mm_job_q.m1;
  assign mm_M2            = mm_job_q.m2;
  assign mm_M3            = mm_job_q.m3;
  assign mm_addr_matrix_a = mm_job_q.addr_a;
  assign mm_addr_matrix_b = mm_job_q.addr_b;
  assign mm_addr_matrix_d = mm_job_q.addr_d;
  assign cpl_valid        = cpl_valid_q;
  assign cpl_tag          = cpl_tag_q;
  assign cpl_status       = cpl_status_q;
  assign busy             = (state_q != S_IDLE) || (count_q != '0) || hung;
  assign jobs_ok          = jobs_ok_q;
  assign jobs_err         = jobs_err_q;

endmodule
